// File: rtl/lzd_pipe.sv
// ---------------------------------------------------------------------------
// lzd_pipe
//
// Purpose:
//   Parametrised, pipelined leading-zero counter for the ICDF GRNG datapath.
//   Counts the zeros from the MSB of a WIDTH-bit word downward, flags
//   all-zero words and carries a sideband tag alongside each result. The
//   block uses a valid/ready stream with backpressure and a synchronous
//   flush. It sits between the uniform-RNG word source and the
//   segment/ROM address generator.
//
// Parameters:
//   WIDTH  input word width, 2..128
//   PIPE   register stages in the tree, 1..4 (latency = PIPE cycles)
//   TAG_W  sideband tag width, >= 1
//   CW     count width, $clog2(WIDTH+1) (derived, not overridable)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous pipeline clear
//   in_valid   input word valid
//   in_ready   block accepts the word this cycle
//   in_data    word to scan
//   in_tag     sideband, passed through unchanged
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_count  leading-zero count, 0..WIDTH
//   out_zero   in_data was all zeros
//   out_tag    tag aligned with the result
//   out_norm   normalised word (in_data << out_count)
//
// Configuration macro:
//   LZD_NORM_EN  when defined, a normalising left shifter is built and
//                out_norm carries the shifted word. When undefined, no
//                shifter or data registers exist and out_norm is tied to 0.
// ---------------------------------------------------------------------------
module lzd_pipe #(
    parameter  int WIDTH = 61,
    parameter  int PIPE  = 2,
    parameter  int TAG_W = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag,
    output logic [WIDTH-1:0] out_norm
);

    // Tree geometry: the word is padded up to P = 2**L bits.
    localparam int L = $clog2(WIDTH);
    localparam int P = 1 << L;

    // Every tree level is packed into a P-bit vector. At level l the vector
    // holds P>>l nodes, each in a 2**l-bit field: the node's valid flag sits
    // in the field's top bit and its l-bit zero position in the low bits.
    // Because l+1 <= 2**l for every level, a field always has room for both,
    // so one register width serves every stage boundary. Level 0 is the
    // padded word itself (one bit per node, which is its own valid flag).
    function automatic logic [P-1:0] merge_level(input logic [P-1:0] cur,
                                                 input int lvl);
        logic [P-1:0] nxt;
        logic [P-1:0] fld_lo;
        logic [P-1:0] fld_hi;
        logic         v_lo;
        logic         v_hi;
        logic [L-1:0] p_lo;
        logic [L-1:0] p_hi;
        logic [L-1:0] mask;
        logic [L-1:0] npos;
        int           f;
        int           base;
        nxt  = '0;
        f    = 1 << lvl;
        mask = L'((1 << lvl) - 1);
        for (int j = 0; j < P / 2; j++) begin
            if (j < (P >> (lvl + 1))) begin
                base   = j * 2 * f;
                fld_lo = cur >> base;
                fld_hi = cur >> (base + f);
                v_lo   = 1'(fld_lo >> (f - 1));
                v_hi   = 1'(fld_hi >> (f - 1));
                p_lo   = L'(fld_lo) & mask;
                p_hi   = L'(fld_hi) & mask;
                // The upper half wins if it holds a one; otherwise the count
                // runs through the whole upper half into the lower one.
                npos   = v_hi ? p_hi : (p_lo | (L'(1) << lvl));
                nxt    = nxt | ((P'(npos) | (P'(v_hi | v_lo) << (2 * f - 1))) << base);
            end
        end
        return nxt;
    endfunction

    // Tree level reached at the output of stage k. Levels are shared out
    // evenly; stage PIPE always finishes the tree.
    function automatic int stage_hi(input int k);
        return (k * L) / PIPE;
    endfunction

    logic [P-1:0]            padded;
    logic [PIPE:1]           valid_q;
    logic [PIPE:1]           adv;
    logic [PIPE:1][P-1:0]    tree_d;
    logic [PIPE:1][P-1:0]    tree_q;
    logic [PIPE:1][TAG_W-1:0] tag_q;
    logic [P-1:0]            root;
    logic                    root_v;
    logic [L-1:0]            root_pos;
    logic [CW-1:0]           cnt;
    logic                    is_zero;
`ifdef LZD_NORM_EN
    logic [PIPE:1][WIDTH-1:0] data_q;
`endif

    // Pad with ones below the LSB so an all-zero word stops at exactly
    // WIDTH. When WIDTH is already a power of two no padding is added.
    always_comb begin
        padded = (P'(in_data) << (P - WIDTH)) | ((P'(1) << (P - WIDTH)) - P'(1));
    end

    // Stage k can advance unless it and every stage after it is full and
    // the sink is stalling. This is the unrolled form of
    // adv_k = ~valid_k | adv_{k+1}, so empty stages still load (bubbles
    // collapse) while the tail is held.
    always_comb begin
        logic full;
        adv = '0;
        for (int k = 1; k <= PIPE; k++) begin
            full = 1'b1;
            for (int j = 1; j <= PIPE; j++) begin
                if (j >= k) begin
                    full = full & valid_q[j];
                end
            end
            adv[k] = out_ready | ~full;
        end
        in_ready = adv[1] & ~flush;
    end

    // Combinational tree slice in front of each stage register.
    always_comb begin
        logic [P-1:0] cur;
        tree_d = '0;
        cur    = padded;
        for (int l = 0; l < L; l++) begin
            if (l < stage_hi(1)) begin
                cur = merge_level(cur, l);
            end
        end
        tree_d[1] = cur;
        for (int k = 2; k <= PIPE; k++) begin
            cur = tree_q[k-1];
            for (int l = 0; l < L; l++) begin
                if (l >= stage_hi(k - 1) && l < stage_hi(k)) begin
                    cur = merge_level(cur, l);
                end
            end
            tree_d[k] = cur;
        end
    end

    // Stage registers. Flush only clears the valid bits; the data registers
    // may keep stale contents because the outputs are gated by valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            tree_q  <= '0;
            tag_q   <= '0;
`ifdef LZD_NORM_EN
            data_q  <= '0;
`endif
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            if (adv[1]) begin
                valid_q[1] <= in_valid;
                if (in_valid) begin
                    tree_q[1] <= tree_d[1];
                    tag_q[1]  <= in_tag;
`ifdef LZD_NORM_EN
                    data_q[1] <= in_data;
`endif
                end
            end
            for (int k = 2; k <= PIPE; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        tree_q[k] <= tree_d[k];
                        tag_q[k]  <= tag_q[k-1];
`ifdef LZD_NORM_EN
                        data_q[k] <= data_q[k-1];
`endif
                    end
                end
            end
        end
    end

    // Decode the root node. A root position of WIDTH can only come from the
    // padding, and a clear root valid only from an unpadded all-zero word;
    // both mean the input was zero. Outputs read 0 whenever nothing is valid,
    // which also gives clean zeros straight out of reset.
    always_comb begin
        root      = tree_q[PIPE];
        root_v    = 1'(root >> (P - 1));
        root_pos  = L'(root);
        cnt       = CW'(root_pos);
        is_zero   = ~root_v | (cnt == CW'(WIDTH));
        out_valid = valid_q[PIPE];
        out_count = '0;
        out_zero  = 1'b0;
        out_tag   = '0;
        if (valid_q[PIPE]) begin
            out_count = is_zero ? CW'(WIDTH) : cnt;
            out_zero  = is_zero;
            out_tag   = tag_q[PIPE];
        end
    end

`ifdef LZD_NORM_EN
    // Normalising shift at the output. Shifting an all-zero word by WIDTH
    // leaves zero, so no special case is needed.
    always_comb begin
        out_norm = '0;
        if (valid_q[PIPE]) begin
            out_norm = data_q[PIPE] << out_count;
        end
    end
`else
    assign out_norm = '0;
`endif

endmodule
